crc8_framer: RTL

CRC8_FRAMER -- requirements
Module: crc8_framer

---
 rtl/crc_pkg.sv | 27 ++
 rtl/crc8_byte_update.sv | 14 +
 rtl/crc8_framer.sv | 134 +++++++++++++
 3 files changed

// File: rtl/crc_pkg.sv
// rtl/crc_pkg.sv - shared state encoding, default constants and CRC-8 byte update for the framer
package crc_pkg;

    typedef enum logic [1:0] {
        ST_PAYLOAD = 2'd0,
        ST_CRC     = 2'd1,
        ST_GAP     = 2'd2
    } state_e;

    localparam logic [7:0] CRC8_DEFAULT_POLY = 8'h07;
    localparam logic [7:0] CRC8_DEFAULT_INIT = 8'hFF;

    // MSB-first, non-reflected, no final XOR
    function automatic logic [7:0] crc8_next(
        input logic [7:0] crc,
        input logic [7:0] data,
        input logic [7:0] poly
    );
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ({c[6:0], 1'b0} ^ poly) : {c[6:0], 1'b0};
        end
        return c;
    endfunction

endpackage

// File: rtl/crc8_byte_update.sv
// rtl/crc8_byte_update.sv - combinational one-byte CRC-8 advance
module crc8_byte_update
    import crc_pkg::*;
#(
    parameter logic [7:0] POLYNOMIAL = CRC8_DEFAULT_POLY
) (
    input  logic [7:0] crc_i,
    input  logic [7:0] data_i,
    output logic [7:0] crc_o
);

    assign crc_o = crc8_next(crc_i, data_i, POLYNOMIAL);

endmodule

// File: rtl/crc8_framer.sv
// rtl/crc8_framer.sv - byte-stream framer that appends or checks a CRC-8 per fixed-size frame
module crc8_framer
    import crc_pkg::*;
#(
    parameter logic [7:0]  POLYNOMIAL    = CRC8_DEFAULT_POLY,
    parameter logic [7:0]  INITIAL       = CRC8_DEFAULT_INIT,
    parameter int unsigned PAYLOAD_BYTES = 8,
    parameter int unsigned GAP_CYCLES    = 2,
    parameter bit          CHECK_MODE    = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    output logic        s_ready,
    output logic [7:0]  m_data,
    output logic        m_valid,
    input  logic        m_ready,
    output logic        m_last,
    output logic [7:0]  byte_counter,
    output logic        crc_err,
    output logic [15:0] err_count
);

    localparam logic [7:0] LAST_PAYLOAD = 8'(PAYLOAD_BYTES - 1);
    localparam logic [7:0] CRC_SLOT     = 8'(PAYLOAD_BYTES);
    localparam logic [7:0] GAP_LAST     = (GAP_CYCLES == 0) ? 8'd0 : 8'(GAP_CYCLES - 1);
    localparam state_e     FRAME_DONE   = (GAP_CYCLES == 0) ? ST_PAYLOAD : ST_GAP;

    state_e      state_q;
    logic [7:0]  crc_q;
    logic [7:0]  crc_d;
    logic [7:0]  cnt_q;
    logic [7:0]  gap_q;
    logic [7:0]  m_data_q;
    logic        m_valid_q;
    logic        m_last_q;
    logic        crc_err_q;
    logic [15:0] err_count_q;

    logic out_free;
    logic s_fire;
    logic final_slot;
    logic check_final;

    crc8_byte_update #(
        .POLYNOMIAL(POLYNOMIAL)
    ) u_crc (
        .crc_i (crc_q),
        .data_i(s_data),
        .crc_o (crc_d)
    );

    assign out_free    = ~m_valid_q | m_ready;
    assign s_ready     = (state_q == ST_PAYLOAD) & out_free;
    assign s_fire      = s_valid & s_ready;
    // check mode carries one extra slot for the received CRC byte
    assign final_slot  = CHECK_MODE ? (cnt_q == CRC_SLOT) : (cnt_q == LAST_PAYLOAD);
    assign check_final = CHECK_MODE & final_slot;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_PAYLOAD;
            crc_q       <= INITIAL;
            cnt_q       <= 8'd0;
            gap_q       <= 8'd0;
            m_data_q    <= 8'd0;
            m_valid_q   <= 1'b0;
            m_last_q    <= 1'b0;
            crc_err_q   <= 1'b0;
            err_count_q <= 16'd0;
        end else begin
            crc_err_q <= 1'b0;
            if (m_valid_q && m_ready) begin
                m_valid_q <= 1'b0;
            end
            case (state_q)
                ST_PAYLOAD: begin
                    if (s_fire) begin
                        m_data_q  <= s_data;
                        m_valid_q <= 1'b1;
                        m_last_q  <= check_final;
                        if (check_final) begin
                            cnt_q   <= 8'd0;
                            gap_q   <= 8'd0;
                            crc_q   <= INITIAL;
                            state_q <= FRAME_DONE;
                            if (s_data != crc_q) begin
                                crc_err_q <= 1'b1;
                                if (err_count_q != 16'hFFFF) begin
                                    err_count_q <= err_count_q + 16'd1;
                                end
                            end
                        end else begin
                            crc_q <= crc_d;
                            cnt_q <= cnt_q + 8'd1;
                            if (final_slot) begin
                                state_q <= ST_CRC;
                            end
                        end
                    end
                end
                ST_CRC: begin
                    if (out_free) begin
                        m_data_q  <= crc_q;
                        m_valid_q <= 1'b1;
                        m_last_q  <= 1'b1;
                        cnt_q     <= 8'd0;
                        gap_q     <= 8'd0;
                        crc_q     <= INITIAL;
                        state_q   <= FRAME_DONE;
                    end
                end
                ST_GAP: begin
                    if (gap_q == GAP_LAST) begin
                        gap_q   <= 8'd0;
                        state_q <= ST_PAYLOAD;
                    end else begin
                        gap_q <= gap_q + 8'd1;
                    end
                end
                default: state_q <= ST_PAYLOAD;
            endcase
        end
    end

    assign m_data       = m_data_q;
    assign m_valid      = m_valid_q;
    assign m_last       = m_last_q;
    assign byte_counter = cnt_q;
    assign crc_err      = crc_err_q;
    assign err_count    = err_count_q;

endmodule
